// File: rtl/posit_batch_sequencer.sv
// posit_batch_sequencer
// Walks a batch of operand pairs held in on-chip memory through a posit adder core.
// Pair i is read from src_base+2i and src_base+2i+1, and its sum is written to dst_base+i.
// Every wait on the core is bounded: if the core does not answer within TIMEOUT cycles,
// the batch aborts and sets the error flag.
//
// Handshake: the operands transfer on a clock edge where io_core_in_valid and
// io_core_in_ready are both high. io_core_in_valid stays high with num1/num2 stable
// until that edge. io_core_out_valid is a one-cycle pulse that is honoured only while
// waiting for a result.
module posit_batch_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W-1:0] io_count,
  input  logic [ADDR_W-1:0] io_src_base,
  input  logic [ADDR_W-1:0] io_dst_base,
  output logic [ADDR_W-1:0] io_rd_addr,
  input  logic [DATA_W-1:0] io_rd_data,
  output logic [ADDR_W-1:0] io_wr_addr,
  output logic [DATA_W-1:0] io_wr_data,
  output logic              io_wr_en,
  output logic              io_core_in_valid,
  input  logic              io_core_in_ready,
  output logic [DATA_W-1:0] io_core_num1,
  output logic [DATA_W-1:0] io_core_num2,
  input  logic              io_core_out_valid,
  input  logic [DATA_W-1:0] io_core_result,
  output logic              io_busy,
  output logic              io_completed,
  output logic              io_error,
  output logic [ADDR_W-1:0] io_processed
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_RDB, S_CAP, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t            state_q;
  logic              start_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] src_ptr_q;
  logic [ADDR_W-1:0] dst_ptr_q;
  logic [ADDR_W-1:0] processed_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] num1_q;
  logic [DATA_W-1:0] num2_q;
  logic [DATA_W-1:0] res_q;
  logic              wr_en_q;
  logic              in_valid_q;
  logic              error_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              start_edge;

  // A start only counts on the rising edge of the PIO level.
  assign start_edge = io_start & ~start_q;

  // Sequencer: one pass through RDA..WRITE per pair. Outputs are registered so they change only on clock edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      count_q     <= '0;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      processed_q <= '0;
      rd_addr_q   <= '0;
      num1_q      <= '0;
      num2_q      <= '0;
      res_q       <= '0;
      wr_en_q     <= 1'b0;
      in_valid_q  <= 1'b0;
      error_q     <= 1'b0;
      tmo_q       <= '0;
    end else begin
      start_q <= io_start;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            count_q     <= io_count;
            src_ptr_q   <= io_src_base;
            dst_ptr_q   <= io_dst_base;
            processed_q <= '0;
            error_q     <= 1'b0;
            if (io_count == '0) begin
              state_q <= S_DONE;
            end else begin
              rd_addr_q <= io_src_base;
              state_q   <= S_RDA;
            end
          end
        end
        S_RDA: begin
          rd_addr_q <= src_ptr_q + ADDR_W'(1);
          state_q   <= S_RDB;
        end
        S_RDB: begin
          num1_q  <= io_rd_data;
          state_q <= S_CAP;
        end
        S_CAP: begin
          num2_q     <= io_rd_data;
          in_valid_q <= 1'b1;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (io_core_in_ready) begin
            in_valid_q <= 1'b0;
            tmo_q      <= '0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (io_core_out_valid) begin
            res_q   <= io_core_result;
            wr_en_q <= 1'b1;
            state_q <= S_WRITE;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            error_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_WRITE: begin
          wr_en_q     <= 1'b0;
          processed_q <= processed_q + ADDR_W'(1);
          src_ptr_q   <= src_ptr_q + ADDR_W'(2);
          dst_ptr_q   <= dst_ptr_q + ADDR_W'(1);
          if ((processed_q + ADDR_W'(1)) == count_q) begin
            state_q <= S_DONE;
          end else begin
            rd_addr_q <= src_ptr_q + ADDR_W'(2);
            state_q   <= S_RDA;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io_rd_addr       = rd_addr_q;
  assign io_wr_addr       = dst_ptr_q;
  assign io_wr_data       = res_q;
  assign io_wr_en         = wr_en_q;
  assign io_core_in_valid = in_valid_q;
  assign io_core_num1     = num1_q;
  assign io_core_num2     = num2_q;
  assign io_busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign io_completed     = (state_q == S_DONE);
  assign io_error         = error_q;
  assign io_processed     = processed_q;

endmodule

// File: tb/tb_posit_batch_sequencer.sv
// Bench for posit_batch_sequencer: the memory, adder core and expected batch results
// are modelled at the level of whole pairs and written words.
module tb_posit_batch_sequencer;

  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset;
  always #5 clock = ~clock;

  logic          io_start;
  logic [AW-1:0] io_count, io_src_base, io_dst_base;
  logic [AW-1:0] io_rd_addr;
  logic [DW-1:0] io_rd_data;
  logic [AW-1:0] io_wr_addr;
  logic [DW-1:0] io_wr_data;
  logic          io_wr_en;
  logic          io_core_in_valid, io_core_in_ready;
  logic [DW-1:0] io_core_num1, io_core_num2;
  logic          io_core_out_valid;
  logic [DW-1:0] io_core_result;
  logic          io_busy, io_completed, io_error;
  logic [AW-1:0] io_processed;

  posit_batch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .io_start(io_start), .io_count(io_count),
    .io_src_base(io_src_base), .io_dst_base(io_dst_base),
    .io_rd_addr(io_rd_addr), .io_rd_data(io_rd_data),
    .io_wr_addr(io_wr_addr), .io_wr_data(io_wr_data), .io_wr_en(io_wr_en),
    .io_core_in_valid(io_core_in_valid), .io_core_in_ready(io_core_in_ready),
    .io_core_num1(io_core_num1), .io_core_num2(io_core_num2),
    .io_core_out_valid(io_core_out_valid), .io_core_result(io_core_result),
    .io_busy(io_busy), .io_completed(io_completed), .io_error(io_error),
    .io_processed(io_processed)
  );

  // ---------------- models and scoreboard state ----------------
  logic [DW-1:0]      mem [0:4095];
  logic [AW+DW-1:0]   exp_q[$];    // expected writes {addr, data}, in order
  logic [2*DW-1:0]    exp_op_q[$]; // expected operand pairs {num1, num2}, in issue order
  logic [AW-1:0]      rd_log[$];
  logic [DW-1:0]      pend_v[$];
  int                 pend_due[$];
  int checks = 0, failures = 0;
  int cyc = 0, wr_count = 0, stall = 0, wait_cnt = 0, last_wait = 0;
  bit core_respond = 1'b1, bp_mode = 1'b0, log_rd = 1'b0;
  bit hold_valid = 1'b0, counting = 1'b0;
  logic [DW-1:0] hold1, hold2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Synchronous-read operand memory, one cycle of latency.
  always @(posedge clock) io_rd_data <= mem[io_rd_addr];

  // Core model and ready driver: result = num1+num2, three cycles after acceptance.
  always @(posedge clock) begin
    #1;
    cyc++;
    io_core_out_valid = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      io_core_out_valid = 1'b1;
      io_core_result    = pend_v[0];
      void'(pend_due.pop_front());
      void'(pend_v.pop_front());
    end
    if (bp_mode) begin
      if (io_core_in_valid && stall < 5) begin
        io_core_in_ready = 1'b0;
        stall++;
      end else begin
        io_core_in_ready = io_core_in_valid;
      end
    end else begin
      io_core_in_ready = 1'b1;
    end
    if (log_rd && io_busy && (rd_log.size() == 0 || rd_log[$] != io_rd_addr))
      rd_log.push_back(io_rd_addr);
  end

  // Compare process, mid-cycle: writes, operand issue and handshake stability.
  always @(negedge clock) begin
    logic [AW+DW-1:0] e;
    logic [2*DW-1:0]  o;
    if (io_wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write", io_wr_addr, io_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(io_wr_addr), 32'(e[AW+DW-1:DW]));
        check("wr_data", 32'(io_wr_data), 32'(e[DW-1:0]));
      end
      mem[io_wr_addr] = io_wr_data;
    end
    if (counting) begin
      if (io_completed) begin last_wait = wait_cnt; counting = 1'b0; end
      else if (!io_busy) counting = 1'b0;
      else wait_cnt++;
    end
    if (io_core_in_valid) begin
      if (!io_busy) begin
        checks++; failures++;
        $display("FAIL in_valid_idle actual=1 required=0");
      end
      if (hold_valid) begin
        check("num1_stable", 32'(io_core_num1), 32'(hold1));
        check("num2_stable", 32'(io_core_num2), 32'(hold2));
      end
      hold_valid = 1'b1; hold1 = io_core_num1; hold2 = io_core_num2;
      if (io_core_in_ready) begin
        hold_valid = 1'b0;
        stall = 0;
        counting = 1'b1;
        wait_cnt = 0;
        if (exp_op_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_issue actual=0x%0h required=no issue", {io_core_num1, io_core_num2});
        end else begin
          o = exp_op_q.pop_front();
          check("issue_operands", {io_core_num1, io_core_num2}, o);
        end
        if (core_respond) begin
          pend_due.push_back(cyc + 3);
          pend_v.push_back(DW'(io_core_num1 + io_core_num2));
        end
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Expected results for a batch, computed from the current memory image.
  task automatic prepare(input int count, input logic [AW-1:0] src, input logic [AW-1:0] dst, input bit tmo);
    logic [AW-1:0] a, b, d;
    logic [DW-1:0] x, y;
    exp_q.delete();
    exp_op_q.delete();
    for (int i = 0; i < count; i++) begin
      a = src + AW'(2 * i);
      b = a + AW'(1);
      d = dst + AW'(i);
      x = mem[a];
      y = mem[b];
      if (!tmo || i == 0) exp_op_q.push_back({x, y});
      if (!tmo) exp_q.push_back({d, DW'(x + y)});
    end
  endtask

  task automatic run(input int count, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                     input bit tmo, input bit glitch, output int n);
    wr_count = 0;
    @(negedge clock);
    io_count = AW'(count); io_src_base = src; io_dst_base = dst; io_start = 1'b1;
    @(posedge clock); #1;
    n = 0;
    while (!io_completed && n < 3000) begin
      @(negedge clock);
      n++;
      if (glitch && n == 8)  io_start = 1'b0;
      if (glitch && n == 10) io_start = 1'b1;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL batch_done actual=busy after %0d cycles required=completed", n);
    end
    @(negedge clock);
    check("completed", 32'(io_completed), 32'd1);
    check("busy_end", 32'(io_busy), 32'd0);
    check("processed", 32'(io_processed), tmo ? 32'd0 : 32'(count));
    check("error", 32'(io_error), tmo ? 32'd1 : 32'd0);
    check("ops_left", 32'(exp_op_q.size()), 32'd0);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(wr_count), tmo ? 32'd0 : 32'(count));
    // Start held high must not retrigger.
    repeat (3) @(negedge clock);
    check("no_retrigger", 32'(io_completed), 32'd1);
    check("no_retrigger_writes", 32'(wr_count), tmo ? 32'd0 : 32'(count));
    io_start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [AW-1:0] src, dst;
    int cnt;
    logic [AW-1:0] wrap_exp [4];
    reset = 1'b1; io_start = 1'b0; io_count = '0; io_src_base = '0; io_dst_base = '0;
    io_core_in_ready = 1'b1; io_core_out_valid = 1'b0; io_core_result = '0; io_rd_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom_range(0, 16'hFFFF));

    repeat (3) @(negedge clock);
    check("rst_busy", 32'(io_busy), 32'd0);
    check("rst_completed", 32'(io_completed), 32'd0);
    check("rst_wr_en", 32'(io_wr_en), 32'd0);
    check("rst_in_valid", 32'(io_core_in_valid), 32'd0);
    check("rst_error", 32'(io_error), 32'd0);
    check("rst_processed", 32'(io_processed), 32'd0);
    check("rst_rd_addr", 32'(io_rd_addr), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_busy", 32'(io_busy), 32'd0);

    // One pair: 0x4000 + 0x4000 lands at 0x010 as 0x8000.
    mem[0] = 16'h4000; mem[1] = 16'h4000;
    prepare(1, 12'h000, 12'h010, 1'b0);
    run(1, 12'h000, 12'h010, 1'b0, 1'b0, n);
    check("pair1_mem", 32'(mem[16]), 32'h8000);

    // Four pairs into 0x010..0x013.
    prepare(4, 12'h000, 12'h010, 1'b0);
    run(4, 12'h000, 12'h010, 1'b0, 1'b0, n);

    // Empty batch.
    prepare(0, 12'h000, 12'h020, 1'b0);
    run(0, 12'h000, 12'h020, 1'b0, 1'b0, n);
    check("count0_latency_ok", 32'(n <= 1), 32'd1);

    // Backpressure.
    bp_mode = 1'b1;
    prepare(3, 12'h040, 12'h840, 1'b0);
    run(3, 12'h040, 12'h840, 1'b0, 1'b0, n);
    bp_mode = 1'b0;

    // Core never answers: abort after TMO cycles of waiting.
    core_respond = 1'b0;
    prepare(3, 12'h200, 12'hA00, 1'b1);
    run(3, 12'h200, 12'hA00, 1'b1, 1'b0, n);
    check("timeout_wait_cycles", 32'(last_wait), 32'd16);
    core_respond = 1'b1;

    // Address wrap on both sides.
    mem[12'hFFE] = 16'h1111; mem[12'hFFF] = 16'h2222;
    mem[12'h000] = 16'h0303; mem[12'h001] = 16'h0404;
    rd_log.delete();
    log_rd = 1'b1;
    prepare(2, 12'hFFE, 12'hFFF, 1'b0);
    run(2, 12'hFFE, 12'hFFF, 1'b0, 1'b0, n);
    log_rd = 1'b0;
    wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;
    check("wrap_rd_count", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < rd_log.size()) check("wrap_rd_addr", 32'(rd_log[i]), 32'(wrap_exp[i]));
    check("wrap_mem_fff", 32'(mem[12'hFFF]), 32'h3333);
    check("wrap_mem_000", 32'(mem[12'h000]), 32'h0707);

    // Asynchronous reset while waiting on the core.
    prepare(3, 12'h100, 12'h900, 1'b0);
    @(negedge clock);
    io_count = 12'd3; io_src_base = 12'h100; io_dst_base = 12'h900; io_start = 1'b1;
    n = 0;
    while (!counting && n < 200) begin @(negedge clock); n++; end
    check("reset_reached_wait", 32'(counting), 32'd1);
    @(posedge clock); #2;
    reset = 1'b1; io_start = 1'b0;
    #1;
    check("async_rst_busy", 32'(io_busy), 32'd0);
    check("async_rst_wr_en", 32'(io_wr_en), 32'd0);
    check("async_rst_in_valid", 32'(io_core_in_valid), 32'd0);
    check("async_rst_processed", 32'(io_processed), 32'd0);
    exp_q.delete(); exp_op_q.delete(); pend_v.delete(); pend_due.delete();
    counting = 1'b0; hold_valid = 1'b0; stall = 0;
    @(negedge clock);
    reset = 1'b0;
    prepare(2, 12'h300, 12'hB00, 1'b0);
    run(2, 12'h300, 12'hB00, 1'b0, 1'b0, n);

    // Randomized batches; one has a start edge during the run.
    for (int k = 0; k < 6; k++) begin
      cnt = $urandom_range(1, 6);
      src = AW'($urandom_range(0, 4095));
      dst = src + 12'h800;
      bp_mode = ($urandom_range(0, 1) == 1);
      prepare(cnt, src, dst, 1'b0);
      run(cnt, src, dst, 1'b0, (k == 2), n);
    end
    bp_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
